alu_exec_unit: RTL and testbench

//  Parametrised EX-stage ALU: decodes ALUOp/Funct3/Funct7 to an op and executes it with a registered result.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_muldiv_iter.sv | 97 +++++++++
 rtl/alu_exec_unit.sv | 172 +++++++++++++++++
 tb/tb_alu_exec_unit.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the EX-stage ALU: operation encoding, control-field constants and FSM states.
package alu_pkg;

    typedef enum logic [4:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_MUL, OP_DIV, OP_DIVU, OP_REM, OP_REMU,
        OP_ILLEGAL
    } alu_op_e;

    localparam logic [1:0] ALUOP_LDST   = 2'b00;
    localparam logic [1:0] ALUOP_R      = 2'b01;
    localparam logic [1:0] ALUOP_BRANCH = 2'b10;
    localparam logic [1:0] ALUOP_I      = 2'b11;

    localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} exec_state_e;

    function automatic logic is_muldiv(input alu_op_e op);
        return (op == OP_MUL) || (op == OP_DIV) || (op == OP_DIVU) ||
               (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative multiplier (shift-add) and restoring divider; one step per cycle, WIDTH steps per op.
// done is asserted combinationally during the final step, with result already reflecting that step.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             start,
    input  alu_op_e          op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic             busy;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] acc, opa, opb;
    logic [WIDTH-1:0] acc_next, opa_next, opb_next;
    logic [WIDTH:0]   trial;
    logic             is_mul, is_rem, neg_q, neg_r, div_zero;
    logic             signed_op;
    logic [WIDTH-1:0] mag_a, mag_b;

    // Signed divides run on magnitudes; signs are reapplied to the final quotient/remainder.
    assign signed_op = (op == OP_DIV) || (op == OP_REM);
    assign mag_a     = (signed_op && src_a[WIDTH-1]) ? -src_a : src_a;
    assign mag_b     = (signed_op && src_b[WIDTH-1]) ? -src_b : src_b;
    assign done      = busy && (count == CNT_W'(WIDTH - 1));

    always_comb begin
        trial    = {acc, opa[WIDTH-1]};
        acc_next = acc;
        opa_next = opa << 1;
        opb_next = opb;
        if (is_mul) begin
            acc_next = opb[0] ? acc + opa : acc;
            opb_next = opb >> 1;
        end else if (trial >= {1'b0, opb}) begin
            acc_next = trial[WIDTH-1:0] - opb;
            opa_next = {opa[WIDTH-2:0], 1'b1};
        end else begin
            acc_next = trial[WIDTH-1:0];
        end
    end

    always_comb begin
        if (is_mul)
            result = acc_next;
        else if (is_rem)
            result = neg_r ? -acc_next : acc_next;
        else if (div_zero)
            result = '1;
        else
            result = neg_q ? -opa_next : opa_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy     <= 1'b0;
            count    <= '0;
            acc      <= '0;
            opa      <= '0;
            opb      <= '0;
            is_mul   <= 1'b0;
            is_rem   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else if (flush) begin
            busy  <= 1'b0;
            count <= '0;
        end else if (start) begin
            busy     <= 1'b1;
            count    <= '0;
            acc      <= '0;
            opa      <= mag_a;
            opb      <= mag_b;
            is_mul   <= (op == OP_MUL);
            is_rem   <= (op == OP_REM) || (op == OP_REMU);
            neg_q    <= signed_op && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
            neg_r    <= signed_op && src_a[WIDTH-1];
            div_zero <= (src_b == '0);
        end else if (busy) begin
            acc   <= acc_next;
            opa   <= opa_next;
            opb   <= opb_next;
            count <= done ? '0 : count + CNT_W'(1);
            busy  <= !done;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage ALU: decodes ALUOp/Funct3/Funct7 and registers the result one cycle after accept.
// Defining ALU_MULDIV_EN adds iterative MUL/DIV/DIVU/REM/REMU that stall via in_ready.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       ALUOp,
    input  logic [6:0]       Funct7,
    input  logic [2:0]       Funct3,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             branch_taken,
    output logic             illegal
);
    localparam int SHW = $clog2(WIDTH);

    exec_state_e      state;
    alu_op_e          dec_op;
    logic             accept, r_type, f7_ok;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] diff, alu_result;
    logic             alu_taken;

    assign in_ready = !reset && (state == IDLE);
    assign accept   = in_valid && in_ready && !flush;
    assign r_type   = (ALUOp == ALUOP_R);
    assign f7_ok    = !r_type || (Funct7 == FUNCT7_BASE);
    assign shamt    = src_b[SHW-1:0];
    assign diff     = src_a - src_b;

    // I-type reuses Funct7 bits as immediate, so it only constrains them for shifts.
    always_comb begin
        dec_op = OP_ILLEGAL;
        case (ALUOp)
            ALUOP_LDST: dec_op = OP_ADD;
            ALUOP_BRANCH: begin
                case (Funct3)
                    3'b000:  dec_op = OP_BEQ;
                    3'b001:  dec_op = OP_BNE;
                    3'b100:  dec_op = OP_BLT;
                    3'b101:  dec_op = OP_BGE;
                    3'b110:  dec_op = OP_BLTU;
                    3'b111:  dec_op = OP_BGEU;
                    default: dec_op = OP_ILLEGAL;
                endcase
            end
            ALUOP_R, ALUOP_I: begin
                if (r_type && Funct7 == FUNCT7_MULDIV) begin
`ifdef ALU_MULDIV_EN
                    case (Funct3)
                        3'b000:  dec_op = OP_MUL;
                        3'b100:  dec_op = OP_DIV;
                        3'b101:  dec_op = OP_DIVU;
                        3'b110:  dec_op = OP_REM;
                        3'b111:  dec_op = OP_REMU;
                        default: dec_op = OP_ILLEGAL;
                    endcase
`else
                    dec_op = OP_ILLEGAL;
`endif
                end else begin
                    case (Funct3)
                        3'b000: if (f7_ok) dec_op = OP_ADD;
                                else if (Funct7 == FUNCT7_ALT) dec_op = OP_SUB;
                        3'b001: if (Funct7 == FUNCT7_BASE) dec_op = OP_SLL;
                        3'b010: if (f7_ok) dec_op = OP_SLT;
                        3'b011: if (f7_ok) dec_op = OP_SLTU;
                        3'b100: if (f7_ok) dec_op = OP_XOR;
                        3'b101: if (Funct7 == FUNCT7_BASE) dec_op = OP_SRL;
                                else if (Funct7 == FUNCT7_ALT) dec_op = OP_SRA;
                        3'b110: if (f7_ok) dec_op = OP_OR;
                        default: if (f7_ok) dec_op = OP_AND;
                    endcase
                end
            end
            default: dec_op = OP_ILLEGAL;
        endcase
    end

    // Illegal and multi-cycle ops fall through to a zero result here.
    always_comb begin
        alu_result = '0;
        alu_taken  = 1'b0;
        case (dec_op)
            OP_ADD:  alu_result = src_a + src_b;
            OP_SUB:  alu_result = diff;
            OP_SLL:  alu_result = src_a << shamt;
            OP_SLT:  alu_result = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            OP_SLTU: alu_result = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
            OP_XOR:  alu_result = src_a ^ src_b;
            OP_SRL:  alu_result = src_a >> shamt;
            OP_SRA:  alu_result = WIDTH'($signed(src_a) >>> shamt);
            OP_OR:   alu_result = src_a | src_b;
            OP_AND:  alu_result = src_a & src_b;
            OP_BEQ:  begin alu_result = diff; alu_taken = (src_a == src_b); end
            OP_BNE:  begin alu_result = diff; alu_taken = (src_a != src_b); end
            OP_BLT:  begin alu_result = diff; alu_taken = ($signed(src_a) < $signed(src_b)); end
            OP_BGE:  begin alu_result = diff; alu_taken = ($signed(src_a) >= $signed(src_b)); end
            OP_BLTU: begin alu_result = diff; alu_taken = (src_a < src_b); end
            OP_BGEU: begin alu_result = diff; alu_taken = (src_a >= src_b); end
            default: ;
        endcase
    end

`ifdef ALU_MULDIV_EN
    logic             md_done;
    logic [WIDTH-1:0] md_result;

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .flush  (flush),
        .start  (accept && is_muldiv(dec_op)),
        .op     (dec_op),
        .src_a  (src_a),
        .src_b  (src_b),
        .done   (md_done),
        .result (md_result)
    );
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            out_valid    <= 1'b0;
            result       <= '0;
            branch_taken <= 1'b0;
            illegal      <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: if (accept) begin
`ifdef ALU_MULDIV_EN
                    if (is_muldiv(dec_op)) begin
                        state <= BUSY;
                    end else begin
`else
                    begin
`endif
                        out_valid    <= 1'b1;
                        result       <= alu_result;
                        branch_taken <= alu_taken;
                        illegal      <= (dec_op == OP_ILLEGAL);
                    end
                end
`ifdef ALU_MULDIV_EN
                BUSY: if (md_done) begin
                    state        <= DONE;
                    out_valid    <= 1'b1;
                    result       <= md_result;
                    branch_taken <= 1'b0;
                    illegal      <= 1'b0;
                end
                DONE: state <= IDLE;
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit; MUL/DIV scenarios run only when ALU_MULDIV_EN is defined.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        reset, in_valid, flush;
    logic [1:0]  ALUOp;
    logic [6:0]  Funct7;
    logic [2:0]  Funct3;
    logic [31:0] src_a, src_b;
    logic        in_ready, out_valid, branch_taken, illegal;
    logic [31:0] result;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]  aluop;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        taken;
        logic        ill;
    } vec_t;

    always #5 clk = ~clk;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .ALUOp        (ALUOp),
        .Funct7       (Funct7),
        .Funct3       (Funct3),
        .src_a        (src_a),
        .src_b        (src_b),
        .flush        (flush),
        .out_valid    (out_valid),
        .result       (result),
        .branch_taken (branch_taken),
        .illegal      (illegal)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        ALUOp    = op;
        Funct3   = f3;
        Funct7   = f7;
        src_a    = a;
        src_b    = b;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        flush = 1'b0;
        drive(2'b01, 3'b000, 7'h00, 32'd5, 32'd7);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({out_valid, branch_taken, illegal, in_ready} !== 4'b0000 || result !== 32'h0) begin
                failures++;
                $display("[TB] FAIL reset_outputs cycle %0d: got ov=%b bt=%b il=%b rdy=%b res=%h, expected all zero",
                         i, out_valid, branch_taken, illegal, in_ready, result);
            end
        end
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_release_ready: got %b expected 1", in_ready);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || result !== 32'd12) begin
            failures++;
            $display("[TB] FAIL first_add: got ov=%b res=%h expected ov=1 res=0000000c", out_valid, result);
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0 || result !== 32'd12) begin
            failures++;
            $display("[TB] FAIL idle_hold: got ov=%b res=%h expected ov=0 res=0000000c", out_valid, result);
        end
    endtask

    task automatic test_alu_ops();
        vec_t v[21];
        v[0]  = '{2'b01, 3'b000, 7'h00, 32'd5,        32'd7,        32'd12,       1'b0, 1'b0};
        v[1]  = '{2'b01, 3'b000, 7'h20, 32'd5,        32'd7,        32'hFFFFFFFE, 1'b0, 1'b0};
        v[2]  = '{2'b01, 3'b001, 7'h00, 32'd1,        32'd33,       32'd2,        1'b0, 1'b0};
        v[3]  = '{2'b01, 3'b010, 7'h00, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1'b0};
        v[4]  = '{2'b01, 3'b011, 7'h00, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 1'b0};
        v[5]  = '{2'b01, 3'b100, 7'h00, 32'h0000F0F0, 32'h00000FF0, 32'h0000FF00, 1'b0, 1'b0};
        v[6]  = '{2'b01, 3'b101, 7'h00, 32'h80000000, 32'd4,        32'h08000000, 1'b0, 1'b0};
        v[7]  = '{2'b01, 3'b110, 7'h00, 32'hF000000F, 32'h00000FF0, 32'hF0000FFF, 1'b0, 1'b0};
        v[8]  = '{2'b01, 3'b111, 7'h00, 32'h0000F0F0, 32'h00000FF0, 32'h000000F0, 1'b0, 1'b0};
        v[9]  = '{2'b11, 3'b101, 7'h20, 32'hFFFFFF00, 32'h00000404, 32'hFFFFFFF0, 1'b0, 1'b0};
        v[10] = '{2'b00, 3'b010, 7'h55, 32'h00000100, 32'hFFFFFFFC, 32'h000000FC, 1'b0, 1'b0};
        v[11] = '{2'b10, 3'b100, 7'h00, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFE, 1'b1, 1'b0};
        v[12] = '{2'b10, 3'b110, 7'h00, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFE, 1'b0, 1'b0};
        v[13] = '{2'b10, 3'b000, 7'h00, 32'h00001234, 32'h00001234, 32'd0,        1'b1, 1'b0};
        v[14] = '{2'b10, 3'b001, 7'h00, 32'h00001234, 32'h00001234, 32'd0,        1'b0, 1'b0};
        v[15] = '{2'b10, 3'b101, 7'h00, 32'd1,        32'hFFFFFFFF, 32'd2,        1'b1, 1'b0};
        v[16] = '{2'b10, 3'b111, 7'h00, 32'd5,        32'd5,        32'd0,        1'b1, 1'b0};
        v[17] = '{2'b01, 3'b000, 7'h00, 32'd3,        32'd4,        32'd7,        1'b0, 1'b0};
        v[18] = '{2'b10, 3'b010, 7'h00, 32'd3,        32'd1,        32'd0,        1'b0, 1'b1};
        v[19] = '{2'b01, 3'b000, 7'h7F, 32'd5,        32'd7,        32'd0,        1'b0, 1'b1};
        v[20] = '{2'b01, 3'b001, 7'h20, 32'd1,        32'd1,        32'd0,        1'b0, 1'b1};
        for (int i = 0; i < 21; i++) begin
            drive(v[i].aluop, v[i].f3, v[i].f7, v[i].a, v[i].b);
            step();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1 || result !== v[i].res ||
                branch_taken !== v[i].taken || illegal !== v[i].ill) begin
                failures++;
                $display("[TB] FAIL alu_vec %0d: got ov=%b rdy=%b res=%h bt=%b il=%b expected ov=1 rdy=1 res=%h bt=%b il=%b",
                         i, out_valid, in_ready, result, branch_taken, illegal, v[i].res, v[i].taken, v[i].ill);
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        drive(2'b01, 3'b101, 7'h20, 32'h80000000, 32'd4);
        step();
        checks++;
        if (out_valid !== 1'b1 || result !== 32'hF8000000 || in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b2b_sra: got ov=%b res=%h rdy=%b expected ov=1 res=f8000000 rdy=1",
                     out_valid, result, in_ready);
        end
        drive(2'b01, 3'b011, 7'h00, 32'd1, 32'd2);
        step();
        checks++;
        if (out_valid !== 1'b1 || result !== 32'd1) begin
            failures++;
            $display("[TB] FAIL b2b_sltu: got ov=%b res=%h expected ov=1 res=00000001", out_valid, result);
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_pulse_end: got ov=%b expected 0", out_valid);
        end
    endtask

    task automatic test_flush();
        drive(2'b01, 3'b000, 7'h00, 32'd100, 32'd200);
        flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || result !== 32'd1 || in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL flush_discard: got ov=%b res=%h rdy=%b expected ov=0 res=00000001 rdy=1",
                     out_valid, result, in_ready);
        end
    endtask

    task automatic test_illegal();
`ifdef ALU_MULDIV_EN
        drive(2'b01, 3'b001, 7'h01, 32'd6, 32'd7);
`else
        drive(2'b01, 3'b000, 7'h01, 32'd6, 32'd7);
`endif
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || illegal !== 1'b1 || result !== 32'd0 || in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL muldiv_encoding_illegal: got ov=%b il=%b res=%h rdy=%b expected ov=1 il=1 res=0 rdy=1",
                     out_valid, illegal, result, in_ready);
        end
        step();
    endtask

`ifdef ALU_MULDIV_EN
    task automatic run_multi(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] res, output int lat, output int ready_seen);
        drive(2'b01, f3, 7'h01, a, b);
        step();
        drive(2'b01, 3'b000, 7'h00, 32'h11, 32'h22);
        lat        = 1;
        ready_seen = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            if (in_ready) ready_seen++;
            step();
            lat++;
        end
        if (in_ready) ready_seen++;
        res      = result;
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_muldiv();
        logic [2:0]  f3s[8]  = '{3'b000, 3'b100, 3'b100, 3'b110, 3'b101, 3'b111, 3'b100, 3'b110};
        logic [31:0] as[8]   = '{32'd7, 32'd9, 32'h80000000, 32'h80000000, 32'd100, 32'd100,
                                 32'hFFFFFFF9, 32'hFFFFFFF9};
        logic [31:0] bs[8]   = '{32'hFFFFFFFD, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7, 32'd7,
                                 32'd2, 32'd2};
        logic [31:0] exps[8] = '{32'hFFFFFFEB, 32'hFFFFFFFF, 32'h80000000, 32'd0, 32'd14, 32'd2,
                                 32'hFFFFFFFD, 32'hFFFFFFFF};
        logic [31:0] res;
        int lat, ready_seen;
        for (int i = 0; i < 8; i++) begin
            run_multi(f3s[i], as[i], bs[i], res, lat, ready_seen);
            checks++;
            if (res !== exps[i] || lat !== 33 || ready_seen !== 0) begin
                failures++;
                $display("[TB] FAIL muldiv_vec %0d: got res=%h lat=%0d ready_cycles=%0d expected res=%h lat=33 ready_cycles=0",
                         i, res, lat, ready_seen, exps[i]);
            end
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                failures++;
                $display("[TB] FAIL muldiv_return_idle %0d: got rdy=%b ov=%b expected rdy=1 ov=0",
                         i, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_muldiv_flush();
        int spurious = 0;
        drive(2'b01, 3'b100, 7'h01, 32'd100, 32'd7);
        step();
        in_valid = 1'b0;
        repeat (9) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL muldiv_flush_idle: got rdy=%b ov=%b expected rdy=1 ov=0", in_ready, out_valid);
        end
        for (int i = 0; i < 40; i++) begin
            step();
            if (out_valid) spurious++;
        end
        checks++;
        if (spurious !== 0 || result !== 32'hFFFFFFFF) begin
            failures++;
            $display("[TB] FAIL muldiv_flush_quiet: got pulses=%0d res=%h expected pulses=0 res=ffffffff",
                     spurious, result);
        end
        drive(2'b01, 3'b000, 7'h00, 32'd2, 32'd3);
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || result !== 32'd5) begin
            failures++;
            $display("[TB] FAIL muldiv_flush_resume: got ov=%b res=%h expected ov=1 res=00000005", out_valid, result);
        end
    endtask
`endif

    initial begin
        in_valid = 1'b0;
        reset    = 1'b1;
        flush    = 1'b0;
        ALUOp    = 2'b00;
        Funct3   = 3'b000;
        Funct7   = 7'h00;
        src_a    = 32'h0;
        src_b    = 32'h0;
        test_reset();
        test_alu_ops();
        test_back_to_back();
        test_flush();
        test_illegal();
`ifdef ALU_MULDIV_EN
        test_muldiv();
        test_muldiv_flush();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
